uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter among NUM_REQ byte requesters (CPU store path, debug monitor, etc.).

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin, packet-locked sharing of one UART transmitter among
//           NUM_REQ byte requesters. Optional idle-lock timeout is enabled by
//           defining ARB_LOCK_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_o,
    input  logic                   tx_busy_i,
    output logic                   timeout_evt_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RISE = 2'd2,
        S_WAIT_FALL = 2'd3
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   last_owner_q;
    logic               last_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q;

    logic               pick_vld_d;
    logic [IDX_W-1:0]   pick_d;
    logic               can_issue_d;
    logic               xfer_d;
    logic               timeout_hit_d;

    // Scan downward so the candidate closest after last_owner wins by overwrite.
    always_comb begin
        int idx;
        idx        = 0;
        pick_vld_d = 1'b0;
        pick_d     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_owner_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid_i[IDX_W'(idx)]) begin
                pick_vld_d = 1'b1;
                pick_d     = IDX_W'(idx);
            end
        end
    end

    assign can_issue_d = (state_q == S_ISSUE) && !tx_busy_i;
    assign xfer_d      = can_issue_d && req_valid_i[owner_q];
    assign req_ready_o = can_issue_d ? grant_q : '0;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] idle_cnt_q;
    logic             timeout_evt_q;
    logic             owner_idle_d;

    assign owner_idle_d  = (state_q == S_ISSUE) && !req_valid_i[owner_q];
    assign timeout_hit_d = owner_idle_d && (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q    <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            timeout_evt_q <= timeout_hit_d;
            if (owner_idle_d && !timeout_hit_d) idle_cnt_q <= idle_cnt_q + 1'b1;
            else                                idle_cnt_q <= '0;
        end
    end

    assign timeout_evt_o = timeout_evt_q;
`else
    assign timeout_hit_d = 1'b0;
    assign timeout_evt_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            last_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        owner_q <= pick_d;
                        grant_q <= NUM_REQ'(1) << pick_d;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (timeout_hit_d) begin
                        grant_q      <= '0;
                        last_owner_q <= owner_q;
                        state_q      <= S_IDLE;
                    end else if (xfer_d) begin
                        tx_data_q  <= req_data_i[{owner_q, 3'b000} +: 8];
                        last_q     <= req_last_i[owner_q];
                        tx_start_q <= 1'b1;
                        state_q    <= S_WAIT_RISE;
                    end
                end
                S_WAIT_RISE: begin
                    if (tx_busy_i) state_q <= S_WAIT_FALL;
                end
                S_WAIT_FALL: begin
                    if (!tx_busy_i) begin
                        if (last_q) begin
                            grant_q      <= '0;
                            last_owner_q <= owner_q;
                            state_q      <= S_IDLE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed bench for uart_tx_arbiter: cycle table plus UART-model
//           sequences. Timeout expectations follow ARB_LOCK_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_last_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  grant_o;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        tx_busy_i;
    logic        timeout_evt_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_last_i   (req_last_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .grant_o      (grant_o),
        .tx_data_o    (tx_data_o),
        .tx_start_o   (tx_start_o),
        .tx_busy_i    (tx_busy_i),
        .timeout_evt_o(timeout_evt_o)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // UART model: busy from 2 cycles after tx_start, for 10 cycles.
    bit   uart_en = 1'b0;
    logic busy_tb = 1'b0;
    int   k = 0;
    always @(posedge clk) begin
        if (!uart_en || rst)  k <= 0;
        else if (tx_start_o)  k <= 1;
        else if (k != 0)      k <= (k == 11) ? 0 : k + 1;
    end
    assign tx_busy_i = uart_en ? (k >= 2) : busy_tb;

    logic [7:0] log_q[$];
    logic [1:0] glog_q[$];
    int   starts = 0, to_cnt = 0, cyc = 0, fall_cyc = 0, to_gap = 0;
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        busy_prev <= tx_busy_i;
        if (uart_en) begin
            if (tx_start_o) begin
                log_q.push_back(tx_data_o);
                glog_q.push_back(grant_o);
                starts <= starts + 1;
            end
            if (busy_prev && !tx_busy_i) fall_cyc <= cyc;
            if (timeout_evt_o) begin
                to_cnt <= to_cnt + 1;
                to_gap <= cyc - fall_cyc;
            end
        end
    end

    logic [8:0] s0[$];
    logic [8:0] s1[$];
    bit early1;

    task automatic clear_logs();
        log_q.delete(); glog_q.delete();
        starts = 0; to_cnt = 0; to_gap = 0; early1 = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req_valid_i = '0; req_last_i = '0; req_data_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic run(input int budget, input bit until_done);
        bit         done;
        logic [1:0] xfer;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (until_done && c > 0 && s0.size() == 0 && s1.size() == 0 &&
                grant_o == 2'b00 && k == 0) begin
                done = 1'b1;
                break;
            end
            req_valid_i = {s1.size() != 0, s0.size() != 0};
            req_data_i  = {(s1.size() != 0) ? s1[0][7:0] : 8'h00,
                           (s0.size() != 0) ? s0[0][7:0] : 8'h00};
            req_last_i  = {(s1.size() != 0) ? s1[0][8] : 1'b0,
                           (s0.size() != 0) ? s0[0][8] : 1'b0};
            @(negedge clk); #1;
            xfer = req_valid_i & req_ready_o;
            if (req_ready_o[1] && s0.size() != 0) early1 = 1'b1;
            @(posedge clk); #1;
            if (xfer[0]) void'(s0.pop_front());
            if (xfer[1]) void'(s1.pop_front());
        end
        if (until_done) chk("run_done", done, 1'b1);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic       busy;
        logic [1:0] e_grant;
        logic [1:0] e_ready;
        logic       e_start;
        logic [7:0] e_data;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic b,
                                input logic [1:0] g, input logic [1:0] rd,
                                input logic s, input logic [7:0] d);
        vec_t x;
        x.rst = r; x.valid = v; x.busy = b;
        x.e_grant = g; x.e_ready = rd; x.e_start = s; x.e_data = d;
        return x;
    endfunction

    initial begin
        //          rst valid busy  grant  ready start data
        vt[0]  = mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
        vt[1]  = mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
        vt[2]  = mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
        vt[3]  = mk(0, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
        vt[4]  = mk(0, 2'b01, 0, 2'b01, 2'b01, 0, 8'h00);
        vt[5]  = mk(0, 2'b00, 0, 2'b01, 2'b00, 1, 8'hA5);
        vt[6]  = mk(0, 2'b00, 1, 2'b01, 2'b00, 0, 8'hA5);
        vt[7]  = mk(0, 2'b00, 1, 2'b01, 2'b00, 0, 8'hA5);
        vt[8]  = mk(0, 2'b00, 0, 2'b01, 2'b00, 0, 8'hA5);
        vt[9]  = mk(0, 2'b10, 0, 2'b00, 2'b00, 0, 8'hA5);
        vt[10] = mk(0, 2'b10, 1, 2'b10, 2'b00, 0, 8'hA5);
        vt[11] = mk(0, 2'b10, 1, 2'b10, 2'b00, 0, 8'hA5);
        vt[12] = mk(0, 2'b10, 0, 2'b10, 2'b10, 0, 8'hA5);
        vt[13] = mk(0, 2'b00, 1, 2'b10, 2'b00, 1, 8'h3C);
        vt[14] = mk(0, 2'b00, 0, 2'b10, 2'b00, 0, 8'h3C);
        vt[15] = mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h3C);

        rst = 1'b1; req_valid_i = 2'b11; req_last_i = 2'b11;
        req_data_i = 16'h3CA5; busy_tb = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = vt[i].rst; req_valid_i = vt[i].valid; busy_tb = vt[i].busy;
            #1;
            chk($sformatf("v%0d_grant", i), grant_o,       vt[i].e_grant);
            chk($sformatf("v%0d_ready", i), req_ready_o,   vt[i].e_ready);
            chk($sformatf("v%0d_start", i), tx_start_o,    vt[i].e_start);
            chk($sformatf("v%0d_data",  i), tx_data_o,     vt[i].e_data);
            chk($sformatf("v%0d_tmo",   i), timeout_evt_o, 1'b0);
        end

        @(posedge clk); #1;
        uart_en = 1'b1;

        // Single-byte packet through the UART model
        reset_dut();
        s0 = {9'h1A5};
        run(200, 1'b1);
        chk("single_count", log_q.size(), 1);
        chk("single_byte",  (log_q.size() > 0) ? log_q[0] : 8'hxx, 8'hA5);
        chk("single_starts", starts, 1);
        chk("single_grant_end", grant_o, 2'b00);

        // Packet lock: req1 waits for req0's two-byte packet
        reset_dut();
        s0 = {9'h001, 9'h102};
        s1 = {9'h103};
        run(300, 1'b1);
        chk("lock_count", log_q.size(), 3);
        chk("lock_b0", (log_q.size() > 2) ? log_q[0] : 8'hxx, 8'h01);
        chk("lock_b1", (log_q.size() > 2) ? log_q[1] : 8'hxx, 8'h02);
        chk("lock_b2", (log_q.size() > 2) ? log_q[2] : 8'hxx, 8'h03);
        chk("lock_early_ready1", early1, 1'b0);

        // Round-robin with single-byte packets (last owner was req1)
        clear_logs();
        s0 = {9'h111, 9'h122};
        s1 = {9'h133, 9'h144};
        run(400, 1'b1);
        chk("rr_count", log_q.size(), 4);
        if (log_q.size() == 4 && glog_q.size() == 4) begin
            chk("rr_b0", log_q[0], 8'h11); chk("rr_g0", glog_q[0], 2'b01);
            chk("rr_b1", log_q[1], 8'h33); chk("rr_g1", glog_q[1], 2'b10);
            chk("rr_b2", log_q[2], 8'h22); chk("rr_g2", glog_q[2], 2'b01);
            chk("rr_b3", log_q[3], 8'h44); chk("rr_g3", glog_q[3], 2'b10);
        end

        // Owner sends a non-last byte then goes quiet while req1 waits
        reset_dut();
        s0 = {9'h055};
        s1 = {9'h166};
`ifdef ARB_LOCK_TIMEOUT_EN
        run(300, 1'b1);
        chk("to_count", log_q.size(), 2);
        chk("to_b0", (log_q.size() > 1) ? log_q[0] : 8'hxx, 8'h55);
        chk("to_b1", (log_q.size() > 1) ? log_q[1] : 8'hxx, 8'h66);
        chk("to_pulses", to_cnt, 1);
        chk("to_gap", to_gap, 9);
        chk("to_grant_end", grant_o, 2'b00);
`else
        run(100, 1'b0);
        chk("hold_count", log_q.size(), 1);
        chk("hold_b0", (log_q.size() > 0) ? log_q[0] : 8'hxx, 8'h55);
        chk("hold_grant", grant_o, 2'b01);
        chk("hold_no_tmo", to_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
